// File: rtl/midi_message_assembler_pkg.sv
// Shared MIDI types and helpers for the message assembler.
//   message_type_t : supported channel-voice status nibbles
//   message_t      : {message_type, data_byte1, data_byte2}, 18 bits
//   asm_state_t    : assembler FSM states
//   is_supported() : status nibble is one the assembler builds messages for
//   data_len()     : number of data bytes a message type carries
package midi_message_assembler_pkg;

  localparam int unsigned BYTE_WIDTH    = 8;
  localparam int unsigned CHANNEL_WIDTH = 4;
  localparam int unsigned DATA_WIDTH    = 7;

  // 0xF8-0xFF are real-time bytes and never disturb message assembly.
  localparam logic [BYTE_WIDTH-1:0] REALTIME_MIN = 8'hF8;

  typedef enum logic {
    DATA   = 1'b0,
    STATUS = 1'b1
  } byte_type_t;

  typedef enum logic [3:0] {
    NOTE_OFF       = 4'h8,
    NOTE_ON        = 4'h9,
    CONTROL_CHANGE = 4'hB,
    PROGRAM_CHANGE = 4'hC
  } message_type_t;

  typedef struct packed {
    message_type_t         message_type;
    logic [DATA_WIDTH-1:0] data_byte1;
    logic [DATA_WIDTH-1:0] data_byte2;
  } message_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2
  } asm_state_t;

  function automatic logic is_supported(message_type_t t);
    case (t)
      NOTE_OFF, NOTE_ON, CONTROL_CHANGE, PROGRAM_CHANGE: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] data_len(message_type_t t);
    return (t == PROGRAM_CHANGE) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_message_assembler_slot.sv
// One-entry valid/ready holding register for finished MIDI messages.
//   load/load_msg/load_channel : a completed message to store
//   msg_ready                  : consumer accepts when msg_valid && msg_ready
//   msg_valid/msg/msg_channel  : held message, stable until accepted
//   overflow                   : 1-cycle pulse when a load finds the slot full
module midi_msg_slot
  import midi_message_assembler_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  message_t                 load_msg,
  input  logic [CHANNEL_WIDTH-1:0] load_channel,
  input  logic                     msg_ready,
  output logic                     msg_valid,
  output message_t                 msg,
  output logic [CHANNEL_WIDTH-1:0] msg_channel,
  output logic                     overflow
);

  logic                     valid_q, valid_d;
  message_t                 msg_q, msg_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic                     overflow_q, overflow_d;
  logic                     accept;

  assign accept = valid_q && msg_ready;

  always_comb begin
    valid_d    = valid_q;
    msg_d      = msg_q;
    chan_d     = chan_q;
    overflow_d = 1'b0;
    if (load && (!valid_q || accept)) begin
      // Accept and reload in the same cycle keeps msg_valid high with no gap.
      valid_d = 1'b1;
      msg_d   = load_msg;
      chan_d  = load_channel;
    end else if (load) begin
      overflow_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      msg_q      <= '0;
      chan_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      msg_q      <= msg_d;
      chan_q     <= chan_d;
      overflow_q <= overflow_d;
    end
  end

  assign msg_valid   = valid_q;
  assign msg         = msg_q;
  assign msg_channel = chan_q;
  assign overflow    = overflow_q;

endmodule

// File: rtl/midi_message_assembler.sv
// Assembles received MIDI bytes into complete channel-voice messages.
//   byte_valid/byte_data : received byte, 1-cycle pulse, no backpressure
//   msg_valid/msg_ready  : output handshake for msg and msg_channel
//   overflow             : pulse when a completed message is dropped (slot full)
// Handles running status, ignores real-time bytes, and drops unsupported or
// system status traffic. With OMNI=0 only messages on CHANNEL are delivered.
module midi_message_assembler
  import midi_message_assembler_pkg::*;
#(
  parameter bit                       OMNI    = 1'b1,
  parameter logic [CHANNEL_WIDTH-1:0] CHANNEL = 4'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     byte_valid,
  input  logic [BYTE_WIDTH-1:0]    byte_data,
  output logic                     msg_valid,
  input  logic                     msg_ready,
  output message_t                 msg,
  output logic [CHANNEL_WIDTH-1:0] msg_channel,
  output logic                     overflow
);

  asm_state_t               state_q, state_d;
  message_type_t            type_q, type_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic [DATA_WIDTH-1:0]    d1_q, d1_d;

  byte_type_t    byte_class;
  logic          is_realtime;
  message_type_t status_type;
  logic          complete;
  message_t      complete_msg;
  logic          chan_match;

  assign byte_class  = byte_type_t'(byte_data[7]);
  assign is_realtime = (byte_data >= REALTIME_MIN);
  assign status_type = message_type_t'(byte_data[7:4]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= NOTE_OFF;
      chan_q  <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      chan_q  <= chan_d;
      d1_q    <= d1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    chan_d  = chan_q;
    d1_d    = d1_q;
    if (byte_valid && !is_realtime) begin
      if (byte_class == STATUS) begin
        if (is_supported(status_type)) begin
          state_d = WAIT_D1;
          type_d  = status_type;
          chan_d  = byte_data[3:0];
        end else begin
          // System or unsupported status kills running status.
          state_d = IDLE;
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          WAIT_D1: begin
            d1_d = byte_data[6:0];
            if (data_len(type_q) == 2'd2) state_d = WAIT_D2;
          end
          WAIT_D2: state_d = WAIT_D1;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    complete     = 1'b0;
    complete_msg = '0;
    if (byte_valid && byte_class == DATA) begin
      unique case (state_q)
        WAIT_D1: begin
          if (data_len(type_q) == 2'd1) begin
            complete                = 1'b1;
            complete_msg.message_type = type_q;
            complete_msg.data_byte1 = byte_data[6:0];
            complete_msg.data_byte2 = '0;
          end
        end
        WAIT_D2: begin
          complete                  = 1'b1;
          complete_msg.message_type = type_q;
          complete_msg.data_byte1   = d1_q;
          complete_msg.data_byte2   = byte_data[6:0];
        end
        default: ;
      endcase
    end
  end

  // Off-channel messages are assembled normally but never reach the slot.
  assign chan_match = OMNI || (chan_q == CHANNEL);

  midi_msg_slot u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (complete && chan_match),
    .load_msg     (complete_msg),
    .load_channel (chan_q),
    .msg_ready    (msg_ready),
    .msg_valid    (msg_valid),
    .msg          (msg),
    .msg_channel  (msg_channel),
    .overflow     (overflow)
  );

endmodule
